// File: rtl/branch_update_queue.sv
// ---------------------------------------------------------------------------
// branch_update_queue
//
// Sits between the execute stage and the BTB. Each resolved control-transfer
// instruction is classified as correctly predicted, mispredicted, and/or
// needing a BTB update. Mispredictions raise a registered one-cycle redirect
// pulse with the correct fetch PC. BTB updates are buffered in a small
// circular FIFO and drained one per cycle into the BTB whenever upd_hold is
// low. Consecutive updates for the same PC coalesce in the newest entry.
//
// Ports
//   clk, rst         : clock and synchronous active-high reset
//   ex_valid         : resolved control-transfer present this cycle
//   ex_pc            : PC of the resolved instruction
//   ex_taken         : actual direction (1 = taken)
//   ex_target        : actual target, BTB target format (33 bits)
//   ex_pred_hit      : fetch-time BTB hit for this instruction
//   ex_pred_target   : fetch-time BTB target for this instruction
//   upd_hold         : blocks draining while high
//   valid_out        : BTB write strobe (head entry valid and not held)
//   branch_PC        : head-entry PC
//   branch_target    : head-entry target
//   redirect         : registered misprediction flush pulse
//   redirect_pc      : correct fetch PC, holds while redirect is low
//   q_count          : current occupancy
//   mispred_cnt      : saturating misprediction counter
//   drop_cnt         : saturating dropped-update counter
// ---------------------------------------------------------------------------
module branch_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    input  logic [31:0]                ex_pc,
    input  logic                       ex_taken,
    input  logic [32:0]                ex_target,
    input  logic                       ex_pred_hit,
    input  logic [32:0]                ex_pred_target,
    input  logic                       upd_hold,
    output logic                       valid_out,
    output logic [31:0]                branch_PC,
    output logic [32:0]                branch_target,
    output logic                       redirect,
    output logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [15:0]                mispred_cnt,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry storage, intentionally not reset.
    logic [31:0] pc_mem  [DEPTH];
    logic [32:0] tgt_mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          redirect_q, redirect_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic [15:0]   mispred_cnt_q, mispred_cnt_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          empty;
    logic          full;
    logic          pop;
    logic          tgt_mismatch;
    logic          mispred;
    logic          need_upd;
    logic [AW-1:0] newest;
    logic          newest_popped;
    logic          coalesce;
    logic          push;
    logic          drop;

    always_comb begin
        empty         = (count_q == '0);
        full          = (count_q == FULL_COUNT);
        pop           = !empty && !upd_hold;
        tgt_mismatch  = (ex_pred_target != ex_target);

        mispred  = ex_valid && ((ex_pred_hit && !ex_taken) ||
                                (ex_taken && !ex_pred_hit) ||
                                (ex_taken && tgt_mismatch));
        need_upd = ex_valid && ex_taken && (!ex_pred_hit || tgt_mismatch);

        // The newest entry is the head only when exactly one entry is held;
        // if that entry is leaving this cycle it can no longer be merged into.
        newest        = wr_ptr_q - AW'(1);
        newest_popped = pop && (count_q == CW'(1));
        coalesce      = need_upd && !empty && !newest_popped &&
                        (pc_mem[newest] == ex_pc);

        // A full queue still takes a push when the head leaves this cycle;
        // the write slot then equals the slot being read out.
        push = need_upd && !coalesce && (!full || pop);
        drop = need_upd && !coalesce && full && !pop;

        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        redirect_d    = mispred;
        redirect_pc_d = redirect_pc_q;
        if (mispred) begin
            redirect_pc_d = ex_taken ? ex_target[31:0] : ex_pc + 32'd4;
        end

        mispred_cnt_d = mispred_cnt_q;
        if (mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + 16'd1;
        end

        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            mispred_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            mispred_cnt_q <= mispred_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Storage writes are gated by rst so a same-cycle reset drops the push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push) begin
                pc_mem[wr_ptr_q]  <= ex_pc;
                tgt_mem[wr_ptr_q] <= ex_target;
            end else if (coalesce) begin
                tgt_mem[newest]   <= ex_target;
            end
        end
    end

    assign valid_out     = pop;
    assign branch_PC     = pc_mem[rd_ptr_q];
    assign branch_target = tgt_mem[rd_ptr_q];
    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign q_count       = count_q;
    assign mispred_cnt   = mispred_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule
